store_drain_unit: RTL and testbench

- Sits directly downstream of the write-back store queue. Tracks how many stores the ROB has committed.
- Pops the store queue one entry at a time through its store_valid / mem_write_en handshake.
- Drives each popped store onto the data-memory write port with a req/ack handshake.
- Supplies a drain-empty indication for fences.

---
 rtl/store_drain_unit_pkg.sv | 12 +
 rtl/store_drain_unit_counter.sv | 33 +++
 rtl/store_drain_unit.sv | 103 ++++++++++
 tb/tb_store_drain_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_drain_unit_pkg.sv
// Shared widths, depth and FSM state encoding for the store drain unit.
package store_drain_unit_pkg;
    localparam int ADDR_WIDTH_DEF    = 32;
    localparam int DATA_WIDTH_DEF    = 32;
    localparam int STORE_QUEUE_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        POP_WAIT = 2'd1,
        BUS_REQ  = 2'd2
    } drain_state_t;
endpackage

// File: rtl/store_drain_unit_counter.sv
// Pending-store counter: adds 0..2 and subtracts 0..1 per cycle, saturating at MAX_VAL.
module sat_up_down_counter #(
    parameter int MAX_VAL = 16,
    parameter int W       = $clog2(MAX_VAL + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o
);
    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   sum;

    always_comb begin
        // One extra bit so an overshoot past MAX_VAL is visible before truncation.
        sum   = {1'b0, cnt_q} + {{(W-1){1'b0}}, inc_i} - {{W{1'b0}}, dec_i};
        sat_o = 1'b0;
        cnt_d = sum[W-1:0];
        if (sum > (W+1)'(MAX_VAL)) begin
            sat_o = 1'b1;
            cnt_d = W'(MAX_VAL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/store_drain_unit.sv
// Drains committed stores from the store queue onto the data-memory write port.
// state    | meaning
// IDLE     | no store in flight; pops when committed stores are pending
// POP_WAIT | pop issued, store queue presents the entry this cycle
// BUS_REQ  | dmem_req held with captured addr/data until dmem_ack
module store_drain_unit
    import store_drain_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int QUEUE      = STORE_QUEUE_DEPTH,
    parameter int CNT_WIDTH  = $clog2(QUEUE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            commit_store_num,
    output logic                  store_valid,
    input  logic                  mem_write_en,
    input  logic [ADDR_WIDTH-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  dmem_req,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ack,
    output logic [CNT_WIDTH-1:0]  pending_cnt,
    output logic                  drain_empty,
    output logic                  err
);
    drain_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [1:0]            commit_eff;
    logic                  bad_commit, pop_err, cnt_sat;

    assign bad_commit = (commit_store_num == 2'd3);
    assign commit_eff = bad_commit ? 2'd2 : commit_store_num;

    sat_up_down_counter #(
        .MAX_VAL (QUEUE),
        .W       (CNT_WIDTH)
    ) u_pending (
        .clk   (clk),
        .rst   (rst),
        .inc_i (commit_eff),
        .dec_i (store_valid),
        .cnt_o (pending_cnt),
        .sat_o (cnt_sat)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        store_valid = 1'b0;
        pop_err     = 1'b0;
        unique case (state_q)
            IDLE: begin
                store_valid = (pending_cnt != '0);
                if (store_valid) state_d = POP_WAIT;
            end
            POP_WAIT: begin
                if (mem_write_en) begin
                    addr_d  = mem_waddr;
                    wdata_d = mem_wdata;
                    state_d = BUS_REQ;
                end else begin
                    pop_err = 1'b1;
                    state_d = IDLE;
                end
            end
            BUS_REQ: begin
                if (dmem_ack) begin
                    // Issue the next pop in the ack cycle to sustain one store per two cycles.
                    store_valid = (pending_cnt != '0);
                    state_d     = store_valid ? POP_WAIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = err_q | pop_err | cnt_sat | bad_commit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign dmem_req    = (state_q == BUS_REQ);
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign drain_empty = (state_q == IDLE) && (pending_cnt == '0);
    assign err         = err_q;
endmodule

// File: tb/tb_store_drain_unit.sv
// Directed bench for store_drain_unit with a store-queue model and a dmem write scoreboard.
module tb_store_drain_unit;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  commit_store_num = 2'd0;
    logic        store_valid;
    logic        mem_write_en = 1'b0;
    logic [31:0] mem_waddr = '0;
    logic [31:0] mem_wdata = '0;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [4:0]  pending_cnt;
    logic        drain_empty;
    logic        err;

    ent_t sq[$];
    ent_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   n_acc    = 0;
    int   n_ent    = 0;
    bit   stub     = 1'b0;

    store_drain_unit dut (
        .clk              (clk),
        .rst              (rst),
        .commit_store_num (commit_store_num),
        .store_valid      (store_valid),
        .mem_write_en     (mem_write_en),
        .mem_waddr        (mem_waddr),
        .mem_wdata        (mem_wdata),
        .dmem_req         (dmem_req),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_ack         (dmem_ack),
        .pending_cnt      (pending_cnt),
        .drain_empty      (drain_empty),
        .err              (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample before the edge, then play the store queue and scoreboard after it.
    task automatic cycle();
        logic        sv_now, acc;
        logic [31:0] a_s, d_s;
        ent_t        e;
        #1;
        sv_now = store_valid;
        acc    = dmem_req && dmem_ack;
        a_s    = dmem_addr;
        d_s    = dmem_wdata;
        @(posedge clk);
        #1;
        commit_store_num = 2'd0;
        if (acc && !rst) begin
            n_acc++;
            check("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("dmem_addr_order", a_s, e.a);
                check("dmem_wdata_order", d_s, e.d);
            end
        end
        mem_write_en = 1'b0;
        mem_waddr    = '0;
        mem_wdata    = '0;
        if (sv_now && !rst && !stub) begin
            check("sq_nonempty", (sq.size() != 0), 1);
            if (sq.size() != 0) begin
                e            = sq.pop_front();
                mem_write_en = 1'b1;
                mem_waddr    = e.a;
                mem_wdata    = e.d;
            end
        end
        #1;
    endtask

    task automatic push_commit(input int n);
        ent_t e;
        int   k;
        logic [1:0] n2;
        n2 = n[1:0];
        commit_store_num = n2;
        k = (n2 == 2'd3) ? 2 : int'(n2);
        for (int i = 0; i < k; i++) begin
            if (!stub) begin
                e.a = 32'h0000_1000 + 32'(n_ent * 4);
                e.d = 32'hDEAD_BEEF + 32'(n_ent);
                sq.push_back(e);
                sb.push_back(e);
            end
            n_ent++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        sq.delete();
        sb.delete();
        n_ent = 0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && !drain_empty; i++) cycle();
        check(tag, drain_empty, 1);
    endtask

    initial begin
        int   peak, reqc, b2b, svc, acc0;
        bit   prev;
        ent_t e;

        // Reset values
        rst = 1'b1;
        cycle();
        cycle();
        check("rst_store_valid", store_valid, 0);
        check("rst_drain_empty", drain_empty, 1);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_pending", pending_cnt, 0);
        check("rst_err", err, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wdata", dmem_wdata, 0);
        rst = 1'b0;
        cycle();

        // Single store, ack tied high
        dmem_ack = 1'b1;
        push_commit(1);
        cycle();
        check("single_pending", pending_cnt, 1);
        check("single_sv", store_valid, 1);
        cycle();
        check("single_popwait_sv", store_valid, 0);
        check("single_popwait_req", dmem_req, 0);
        cycle();
        check("single_req", dmem_req, 1);
        check("single_addr", dmem_addr, 32'h0000_1000);
        check("single_wdata", dmem_wdata, 32'hDEAD_BEEF);
        cycle();
        check("single_drain_empty", drain_empty, 1);
        check("single_err", err, 0);
        check("single_req_drop", dmem_req, 0);

        // Burst 2,2,1 with ack high
        peak = 0; reqc = 0; b2b = 0; prev = 0; acc0 = n_acc;
        for (int s = 0; s < 43; s++) begin
            if (s == 0 || s == 1) push_commit(2);
            else if (s == 2) push_commit(1);
            else if (drain_empty) break;
            cycle();
            if (int'(pending_cnt) > peak) peak = int'(pending_cnt);
            if (dmem_req) begin
                reqc++;
                if (prev) b2b++;
            end
            prev = dmem_req;
        end
        check("burst_drained", drain_empty, 1);
        check("burst_peak", peak, 4);
        check("burst_req_cycles", reqc, 5);
        check("burst_req_b2b", b2b, 0);
        check("burst_accepts", n_acc - acc0, 5);
        check("burst_pending_end", pending_cnt, 0);
        check("burst_err", err, 0);

        // Backpressure: ack low for 10 cycles while 3 more stores commit
        dmem_ack = 1'b0;
        acc0 = n_acc;
        push_commit(1);
        cycle();
        cycle();
        cycle();
        check("bp_req", dmem_req, 1);
        e = sb[0];
        svc = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 3) push_commit(1);
            cycle();
            if (store_valid) svc++;
            check("bp_addr_stable", dmem_addr, e.a);
            check("bp_wdata_stable", dmem_wdata, e.d);
        end
        check("bp_pending", pending_cnt, 3);
        check("bp_no_extra_sv", svc, 0);
        check("bp_req_held", dmem_req, 1);
        dmem_ack = 1'b1;
        #1;
        check("bp_sv_on_ack", store_valid, 1);
        cycle();
        check("bp_pending_after_ack", pending_cnt, 2);
        drain("bp_drained");
        check("bp_accepts", n_acc - acc0, 4);
        check("bp_err", err, 0);

        // Overflow: 2 commits per cycle for 9 cycles, no ack
        dmem_ack = 1'b0;
        for (int i = 0; i < 9; i++) begin
            push_commit(2);
            cycle();
        end
        check("ovf_pending", pending_cnt, 16);
        check("ovf_err", err, 1);
        cycle();
        cycle();
        cycle();
        check("ovf_err_sticky", err, 1);
        check("ovf_pending_hold", pending_cnt, 16);
        do_reset();
        check("ovf_rst_err", err, 0);

        // Illegal commit value 3 counts as 2 and flags err
        push_commit(3);
        cycle();
        check("c3_pending", pending_cnt, 2);
        check("c3_err", err, 1);
        dmem_ack = 1'b1;
        drain("c3_drained");
        do_reset();

        // Protocol error: store queue never raises mem_write_en
        stub = 1'b1;
        push_commit(1);
        cycle();
        check("perr_sv", store_valid, 1);
        cycle();
        check("perr_pending_dec", pending_cnt, 0);
        check("perr_err_pre", err, 0);
        cycle();
        check("perr_err", err, 1);
        check("perr_req", dmem_req, 0);
        check("perr_idle", drain_empty, 1);
        stub = 1'b0;
        do_reset();

        // Reset while dmem_req is outstanding with 5 pending
        dmem_ack = 1'b0;
        push_commit(2);
        cycle();
        push_commit(2);
        cycle();
        push_commit(2);
        cycle();
        check("mrst_req_before", dmem_req, 1);
        check("mrst_pending_before", pending_cnt, 5);
        rst = 1'b1;
        cycle();
        check("mrst_req", dmem_req, 0);
        check("mrst_pending", pending_cnt, 0);
        check("mrst_drain_empty", drain_empty, 1);
        check("mrst_err", err, 0);
        rst = 1'b0;
        sq.delete();
        sb.delete();
        cycle();
        check("mrst_sv_after", store_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
